// File: rtl/trace_rom_pkg.sv
// Shared definitions for the per-core interface trace ROMs.
// Holds the opcode encodings, the ROM geometry, the helpers that pack the
// send/receive payloads, and the helpers that give each core its base
// address (A_k) and base data word (D_k).
package trace_rom_pkg;

    localparam int rom_width_c     = 73;  // {opcode[3:0], payload[68:0]}
    localparam int payload_width_c = 69;
    localparam int last_entry_c    = 11;  // index of the final done entry
    localparam int error_limit_c   = 12;  // addresses above this flag an overrun

    typedef enum logic [3:0] {
        op_nop        = 4'b0000,
        op_send       = 4'b0001,
        op_receive    = 4'b0010,
        op_done       = 4'b0011,
        op_finish     = 4'b0100,
        op_cycle_init = 4'b0101,
        op_cycle_dec  = 4'b0110
    } opcode_e;

    // Send payload: {4'b0, we, addr, wdata}. Loads pass wdata = 0.
    function automatic logic [payload_width_c-1:0] pack_send(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        return {4'b0000, we, addr, wdata};
    endfunction

    // Receive payload: the expected read data, zero-extended.
    function automatic logic [payload_width_c-1:0] pack_recv(
        input logic [31:0] rdata
    );
        return {37'b0, rdata};
    endfunction

    // A_k = 0x80 * k keeps each core in its own cache-line region.
    function automatic logic [31:0] a_k(input int k);
        return 32'(k) << 7;
    endfunction

    // D_k = 0xC0DE_0000 + k makes every core's data distinguishable.
    function automatic logic [31:0] d_k(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

endpackage

// File: rtl/bsg_core_intf_trace_rom_wrappers.sv
// Fixed-core wrappers around core_intf_trace_rom for parents that have no
// clock or reset to offer. Clock and reset are tied low, so the overrun
// flag is unused and left unconnected.
// Ports (each wrapper):
//   addr_i - trace entry index
//   data_o - trace entry {opcode, payload}
module bsg_core_intf_trace_rom0 #(
    parameter int width_p      = 73,
    parameter int addr_width_p = 15
) (
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o
);
    core_intf_trace_rom #(
        .width_p(width_p), .addr_width_p(addr_width_p), .core_id_p(0)
    ) u_rom (
        .clk_i(1'b0), .reset_i(1'b0), .addr_i(addr_i), .data_o(data_o), .error_o()
    );
endmodule

module bsg_core_intf_trace_rom1 #(
    parameter int width_p      = 73,
    parameter int addr_width_p = 15
) (
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o
);
    core_intf_trace_rom #(
        .width_p(width_p), .addr_width_p(addr_width_p), .core_id_p(1)
    ) u_rom (
        .clk_i(1'b0), .reset_i(1'b0), .addr_i(addr_i), .data_o(data_o), .error_o()
    );
endmodule

module bsg_core_intf_trace_rom2 #(
    parameter int width_p      = 73,
    parameter int addr_width_p = 15
) (
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o
);
    core_intf_trace_rom #(
        .width_p(width_p), .addr_width_p(addr_width_p), .core_id_p(2)
    ) u_rom (
        .clk_i(1'b0), .reset_i(1'b0), .addr_i(addr_i), .data_o(data_o), .error_o()
    );
endmodule

// File: rtl/core_intf_trace_rom.sv
// Per-core trace program for cache-interface replay.
// Ports:
//   clk_i   - clock, only used to sample the overrun flag
//   reset_i - asynchronous active-high reset, clears error_o only
//   addr_i  - trace entry index
//   data_o  - trace entry {opcode, payload}, purely combinational from addr_i
//   error_o - sticky: set on a clock edge that sees addr_i past the end
module core_intf_trace_rom
    import trace_rom_pkg::*;
#(
    parameter int width_p      = 73,
    parameter int addr_width_p = 15,
    parameter int core_id_p    = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o,
    output logic                    error_o
);

    if (core_id_p < 0 || core_id_p > 2) begin : g_bad_core
        $fatal(1, "core_intf_trace_rom: core_id_p=%0d is outside 0..2", core_id_p);
    end

    localparam logic [31:0] base_addr_c  = a_k(core_id_p);
    localparam logic [31:0] base_data_c  = d_k(core_id_p);
    // Same cache set as base_addr_c but a different tag, so the store at
    // entry 6 forces a fill or eviction before the base line is re-read.
    localparam logic [31:0] evict_addr_c = base_addr_c + 32'h0000_0400;
    localparam logic [31:0] evict_data_c = base_data_c ^ 32'h0000_FFFF;

    logic                   in_range;
    logic [3:0]             idx;
    logic [rom_width_c-1:0] rom_entry;
    logic                   past_end;
    logic                   error_q;

    assign in_range = (addr_i <= addr_width_p'(last_entry_c));
    assign idx      = addr_i[3:0];

    // Anything beyond the last entry reads as done so a replay engine that
    // overruns simply stops instead of executing garbage.
    always_comb begin
        rom_entry = {op_done, {payload_width_c{1'b0}}};
        if (in_range) begin
            case (idx)
                4'd0:    rom_entry = {op_send,    pack_send(1'b1, base_addr_c, base_data_c)};
                4'd1:    rom_entry = {op_send,    pack_send(1'b1, base_addr_c + 32'd4, ~base_data_c)};
                4'd2:    rom_entry = {op_send,    pack_send(1'b0, base_addr_c, 32'd0)};
                4'd3:    rom_entry = {op_receive, pack_recv(base_data_c)};
                4'd4:    rom_entry = {op_send,    pack_send(1'b0, base_addr_c + 32'd4, 32'd0)};
                4'd5:    rom_entry = {op_receive, pack_recv(~base_data_c)};
                4'd6:    rom_entry = {op_send,    pack_send(1'b1, evict_addr_c, evict_data_c)};
                4'd7:    rom_entry = {op_send,    pack_send(1'b0, base_addr_c, 32'd0)};
                4'd8:    rom_entry = {op_receive, pack_recv(base_data_c)};
                4'd9:    rom_entry = {op_send,    pack_send(1'b0, evict_addr_c, 32'd0)};
                4'd10:   rom_entry = {op_receive, pack_recv(evict_data_c)};
                default: rom_entry = {op_done, {payload_width_c{1'b0}}};
            endcase
        end
    end

    assign data_o = width_p'(rom_entry);

    assign past_end = (addr_i > addr_width_p'(error_limit_c));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else if (past_end) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;

endmodule

// File: tb/tb_core_intf_trace_rom.sv
// Bench for core_intf_trace_rom: three instances (cores 0..2) share one
// address bus. Expected entries come from a small independent model and
// flow through a scoreboard queue; a replay walk plays each trace against
// a memory model to confirm every receive matches what was stored.
module tb_core_intf_trace_rom;

    logic        clk;
    logic        reset_i;
    logic [14:0] addr_i;
    logic [72:0] data0, data1, data2;
    logic        err0, err1, err2;

    int checks = 0;
    int errors = 0;

    logic [72:0] exp_q[$];
    int          core_q[$];

    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(0)) u_dut0 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_o(data0), .error_o(err0)
    );
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_o(data1), .error_o(err1)
    );
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(2)) u_dut2 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_o(data2), .error_o(err2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [72:0] dut_data(input int k);
        case (k)
            0:       return data0;
            1:       return data1;
            default: return data2;
        endcase
    endfunction

    function automatic logic dut_err(input int k);
        case (k)
            0:       return err0;
            1:       return err1;
            default: return err2;
        endcase
    endfunction

    // Independent reference model of the trace table.
    function automatic logic [72:0] model(input int k, input int a);
        logic [31:0] ak, dk;
        ak = 32'h80 * k;
        dk = 32'hC0DE_0000 + k;
        case (a)
            0:       return {4'b0001, 4'b0, 1'b1, ak, dk};
            1:       return {4'b0001, 4'b0, 1'b1, ak + 32'd4, ~dk};
            2:       return {4'b0001, 4'b0, 1'b0, ak, 32'h0};
            3:       return {4'b0010, 37'b0, dk};
            4:       return {4'b0001, 4'b0, 1'b0, ak + 32'd4, 32'h0};
            5:       return {4'b0010, 37'b0, ~dk};
            6:       return {4'b0001, 4'b0, 1'b1, ak + 32'h400, dk ^ 32'hFFFF};
            7:       return {4'b0001, 4'b0, 1'b0, ak, 32'h0};
            8:       return {4'b0010, 37'b0, dk};
            9:       return {4'b0001, 4'b0, 1'b0, ak + 32'h400, 32'h0};
            10:      return {4'b0010, 37'b0, dk ^ 32'hFFFF};
            default: return {4'b0011, 69'b0};
        endcase
    endfunction

    task automatic test_reset();
        logic [72:0] exp_e;
        reset_i = 1'b1;
        addr_i  = 15'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_err(k) !== 1'b0) begin
                errors++;
                $display("FAIL reset_error core%0d: got %b want 0", k, dut_err(k));
            end
        end
        // data must be valid while reset is held
        exp_e = {4'b0001, 4'b0, 1'b1, 32'h0, 32'hC0DE_0000};
        checks++;
        if (data0 !== exp_e) begin
            errors++;
            $display("FAIL reset_data: got %h want %h", data0, exp_e);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_spec_vectors();
        logic [72:0] exp_e;
        @(negedge clk);
        addr_i = 15'd0;
        #1;
        exp_e = {4'b0001, 4'b0, 1'b1, 32'h0000_0000, 32'hC0DE_0000};
        checks++;
        if (data0 !== exp_e) begin
            errors++;
            $display("FAIL vec_core0_addr0: got %h want %h", data0, exp_e);
        end
        addr_i = 15'd3;
        #1;
        exp_e = {4'b0010, 37'b0, 32'hC0DE_0001};
        checks++;
        if (data1 !== exp_e) begin
            errors++;
            $display("FAIL vec_core1_addr3: got %h want %h", data1, exp_e);
        end
        addr_i = 15'd6;
        #1;
        exp_e = {4'b0001, 4'b0, 1'b1, 32'h0000_0500, 32'hC0DE_FFFD};
        checks++;
        if (data2 !== exp_e) begin
            errors++;
            $display("FAIL vec_core2_addr6: got %h want %h", data2, exp_e);
        end
    endtask

    // Every entry 0..12 on all three cores, checked through the scoreboard.
    task automatic test_trace_table();
        logic [72:0] exp_e, act;
        int          k;
        for (int a = 0; a <= 12; a++) begin
            @(negedge clk);
            addr_i = 15'(a);
            for (int c = 0; c < 3; c++) begin
                exp_q.push_back(model(c, a));
                core_q.push_back(c);
            end
            #1;
            while (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                k     = core_q.pop_front();
                act   = dut_data(k);
                checks++;
                if (act !== exp_e) begin
                    errors++;
                    $display("FAIL table core%0d addr%0d: got %h want %h", k, a, act, exp_e);
                end
            end
        end
    endtask

    // High addresses are applied and withdrawn between clock edges so the
    // overrun flag is not disturbed here.
    task automatic test_done_tail();
        logic [14:0] addrs[4];
        logic [72:0] exp_e, act;
        int          k;
        addrs[0] = 15'd11;
        addrs[1] = 15'h7FFF;
        addrs[2] = 15'(13 + $urandom_range(0, 1000));
        addrs[3] = 15'(2000 + $urandom_range(0, 30000));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr_i = addrs[i];
            for (int c = 0; c < 3; c++) begin
                exp_q.push_back({4'b0011, 69'b0});
                core_q.push_back(c);
            end
            #1;
            while (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                k     = core_q.pop_front();
                act   = dut_data(k);
                checks++;
                if (act !== exp_e) begin
                    errors++;
                    $display("FAIL done_tail core%0d addr%h: got %h want %h", k, addrs[i], act, exp_e);
                end
            end
            addr_i = 15'd0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL error_between_edges: got %b want 0", err0);
        end
    endtask

    task automatic test_error_sticky();
        // addr 12 is the last address that does not flag
        @(negedge clk);
        addr_i = 15'd12;
        @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL error_at_12: got %b want 0", err0);
        end
        @(negedge clk);
        addr_i = 15'd20;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_err(k) !== 1'b1) begin
                errors++;
                $display("FAIL error_set core%0d: got %b want 1", k, dut_err(k));
            end
        end
        @(negedge clk);
        addr_i = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b want 1", err0);
        end
        // asynchronous clear between edges
        @(negedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL error_async_clear: got %b want 0", err0);
        end
        #1;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL error_after_clear: got %b want 0", err0);
        end
        @(negedge clk);
        addr_i = 15'd13;
        @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b1) begin
            errors++;
            $display("FAIL error_at_13: got %b want 1", err0);
        end
    endtask

    task automatic test_reset_mid();
        logic [72:0] exp_e;
        @(negedge clk);
        addr_i  = 15'd5;
        reset_i = 1'b1;
        #1;
        exp_e = {4'b0010, 37'b0, ~(32'hC0DE_0002)};
        checks++;
        if (data2 !== exp_e) begin
            errors++;
            $display("FAIL reset_mid_data: got %h want %h", data2, exp_e);
        end
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_error: got %b want 0", err1);
        end
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    // Replay each trace against a memory model: stores write, loads push the
    // stored value to the scoreboard, receives pop and compare.
    task automatic test_replay();
        logic [31:0] mem[logic [31:0]];
        logic [72:0] d;
        logic [72:0] exp_e;
        int          recv_cnt;
        bit          reached;
        for (int k = 0; k < 3; k++) begin
            mem.delete();
            exp_q.delete();
            recv_cnt = 0;
            reached  = 1'b0;
            for (int pc = 0; pc < 64 && !reached; pc++) begin
                @(negedge clk);
                addr_i = 15'(pc);
                #1;
                d = dut_data(k);
                case (d[72:69])
                    4'b0001: begin
                        if (d[64]) mem[d[63:32]] = d[31:0];
                        else exp_q.push_back({41'b0, mem.exists(d[63:32]) ? mem[d[63:32]] : 32'hDEAD_BEEF});
                    end
                    4'b0010: begin
                        recv_cnt++;
                        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 73'h1_DEAD_BEEF;
                        checks++;
                        if ({41'b0, d[31:0]} !== exp_e) begin
                            errors++;
                            $display("FAIL replay_recv core%0d pc%0d: got %h want %h", k, pc, d[31:0], exp_e[31:0]);
                        end
                    end
                    4'b0011: reached = 1'b1;
                    default: ;
                endcase
            end
            checks++;
            if (!reached || recv_cnt != 4 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL replay_done core%0d: reached=%0d recvs=%0d pending=%0d want 1/4/0",
                         k, reached, recv_cnt, exp_q.size());
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_trace_table();
        test_done_tail();
        test_replay();
        test_error_sticky();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
